// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped branch predictor with 2-bit saturating
//                counters and a stored branch target. The lookup path is
//                combinational from IF_PC. The update path is driven by the
//                branch resolving in EX. This module also produces the
//                mispredict flush and the redirect PC.
//                Optional macro BP_PERF_COUNTERS_EN adds branch and
//                mispredict event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
   parameter int ENTRIES = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] IF_PC,
   output logic        PREDICT_TAKEN,
   output logic [31:0] PREDICT_TARGET,
   input  logic        EX_BRANCH_VALID,
   input  logic [31:0] EX_PC,
   input  logic [31:0] EX_TARGET,
   input  logic        EX_BRANCH_TAKEN,
   input  logic        EX_PRED_TAKEN,
   input  logic [31:0] EX_PRED_TARGET,
`ifdef BP_PERF_COUNTERS_EN
   output logic [31:0] BRANCH_COUNT,
   output logic [31:0] MISPREDICT_COUNT,
`endif
   output logic        MISPREDICT,
   output logic [31:0] REDIRECT_PC
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   localparam logic [1:0] c_SNT = 2'b00;
   localparam logic [1:0] c_WNT = 2'b01;
   localparam logic [1:0] c_WT  = 2'b10;
   localparam logic [1:0] c_ST  = 2'b11;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];

   logic [IDX_W-1:0] w_if_idx;
   logic [IDX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0] w_if_tag;
   logic [TAG_W-1:0] w_ex_tag;
   logic             w_if_hit;
   logic             w_ex_hit;
   logic [1:0]       w_ctr_next;

   // The low two PC bits are never part of the index or the tag
   assign w_if_idx = IF_PC[IDX_W+1:2];
   assign w_if_tag = IF_PC[31:IDX_W+2];
   assign w_ex_idx = EX_PC[IDX_W+1:2];
   assign w_ex_tag = EX_PC[31:IDX_W+2];

   assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

   // Lookup reads pre-edge table contents, so there is no bypass from EX
   always_comb begin
      PREDICT_TAKEN  = w_if_hit && r_ctr[w_if_idx][1];
      PREDICT_TARGET = PREDICT_TAKEN ? r_target[w_if_idx] : (IF_PC + 32'd4);
   end

   // Mispredict and redirect depend on EX inputs only, including during reset
   always_comb begin
      MISPREDICT  = EX_BRANCH_VALID &&
                    ((EX_BRANCH_TAKEN != EX_PRED_TAKEN) ||
                     (EX_BRANCH_TAKEN && (EX_PRED_TARGET != EX_TARGET)));
      REDIRECT_PC = EX_BRANCH_TAKEN ? EX_TARGET : (EX_PC + 32'd4);
   end

   // Saturating counter step for the entry being trained
   always_comb begin
      w_ctr_next = r_ctr[w_ex_idx];
      if (EX_BRANCH_TAKEN) begin
         if (r_ctr[w_ex_idx] != c_ST) begin
            w_ctr_next = r_ctr[w_ex_idx] + 2'b01;
         end
      end else begin
         if (r_ctr[w_ex_idx] != c_SNT) begin
            w_ctr_next = r_ctr[w_ex_idx] - 2'b01;
         end
      end
   end

   // Table training; a not-taken miss leaves the table alone
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= c_WNT;
         end
      end else if (EX_BRANCH_VALID) begin
         if (w_ex_hit) begin
            r_ctr[w_ex_idx] <= w_ctr_next;
            if (EX_BRANCH_TAKEN) begin
               r_target[w_ex_idx] <= EX_TARGET;
            end
         end else if (EX_BRANCH_TAKEN) begin
            r_valid[w_ex_idx]  <= 1'b1;
            r_tag[w_ex_idx]    <= w_ex_tag;
            r_target[w_ex_idx] <= EX_TARGET;
            r_ctr[w_ex_idx]    <= c_WT;
         end
      end
   end

`ifdef BP_PERF_COUNTERS_EN
   logic [31:0] r_branch_cnt;
   logic [31:0] r_mispred_cnt;

   // Free-running event counters, wrapping naturally at 2^32
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else begin
         if (EX_BRANCH_VALID) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
         end
         if (MISPREDICT) begin
            r_mispred_cnt <= r_mispred_cnt + 32'd1;
         end
      end
   end

   assign BRANCH_COUNT     = r_branch_cnt;
   assign MISPREDICT_COUNT = r_mispred_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor. It applies a
//                directed vector table and then randomized traffic checked
//                against a behavioural table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

   typedef struct {
      logic        rst_n;
      logic [31:0] if_pc;
      logic        ex_v;
      logic [31:0] ex_pc;
      logic [31:0] ex_tgt;
      logic        ex_tk;
      logic        ex_ptk;
      logic [31:0] ex_ptgt;
      logic        exp_pt;
      logic [31:0] exp_ptgt;
      logic        exp_mp;
      logic [31:0] exp_redir;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] IF_PC;
   logic        PREDICT_TAKEN;
   logic [31:0] PREDICT_TARGET;
   logic        EX_BRANCH_VALID;
   logic [31:0] EX_PC;
   logic [31:0] EX_TARGET;
   logic        EX_BRANCH_TAKEN;
   logic        EX_PRED_TAKEN;
   logic [31:0] EX_PRED_TARGET;
   logic        MISPREDICT;
   logic [31:0] REDIRECT_PC;
`ifdef BP_PERF_COUNTERS_EN
   logic [31:0] BRANCH_COUNT;
   logic [31:0] MISPREDICT_COUNT;
`endif

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   branch_predictor #(.ENTRIES(16)) dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .IF_PC           (IF_PC),
      .PREDICT_TAKEN   (PREDICT_TAKEN),
      .PREDICT_TARGET  (PREDICT_TARGET),
      .EX_BRANCH_VALID (EX_BRANCH_VALID),
      .EX_PC           (EX_PC),
      .EX_TARGET       (EX_TARGET),
      .EX_BRANCH_TAKEN (EX_BRANCH_TAKEN),
      .EX_PRED_TAKEN   (EX_PRED_TAKEN),
      .EX_PRED_TARGET  (EX_PRED_TARGET),
`ifdef BP_PERF_COUNTERS_EN
      .BRANCH_COUNT    (BRANCH_COUNT),
      .MISPREDICT_COUNT(MISPREDICT_COUNT),
`endif
      .MISPREDICT      (MISPREDICT),
      .REDIRECT_PC     (REDIRECT_PC)
   );

   // ---------------- behavioural reference model ----------------
   bit          m_valid [16];
   logic [25:0] m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   logic [31:0] m_bc;
   logic [31:0] m_mc;

   function automatic bit m_hit(input logic [31:0] pc);
      int idx;
      idx = int'((pc >> 2) % 16);
      return m_valid[idx] && (m_tag[idx] == pc[31:6]);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[int'((pc >> 2) % 16)] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
      return m_pred(pc) ? m_tgt[int'((pc >> 2) % 16)] : pc + 32'd4;
   endfunction

   function automatic bit m_mispredict();
      if (!EX_BRANCH_VALID) return 1'b0;
      if (EX_BRANCH_TAKEN != EX_PRED_TAKEN) return 1'b1;
      return EX_BRANCH_TAKEN && (EX_PRED_TARGET != EX_TARGET);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_bc = '0;
      m_mc = '0;
   endtask

   // Model state change for the inputs present at a rising edge
   task automatic m_edge();
      int idx;
      if (!RESET) begin
         m_reset();
      end else if (EX_BRANCH_VALID) begin
         m_bc = m_bc + 32'd1;
         if (m_mispredict()) m_mc = m_mc + 32'd1;
         idx = int'((EX_PC >> 2) % 16);
         if (m_hit(EX_PC)) begin
            if (EX_BRANCH_TAKEN) begin
               m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
               m_tgt[idx] = EX_TARGET;
            end else begin
               m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
            end
         end else if (EX_BRANCH_TAKEN) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = EX_PC[31:6];
            m_tgt[idx]   = EX_TARGET;
            m_ctr[idx]   = 2;
         end
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int step,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      RESET           = v.rst_n;
      IF_PC           = v.if_pc;
      EX_BRANCH_VALID = v.ex_v;
      EX_PC           = v.ex_pc;
      EX_TARGET       = v.ex_tgt;
      EX_BRANCH_TAKEN = v.ex_tk;
      EX_PRED_TAKEN   = v.ex_ptk;
      EX_PRED_TARGET  = v.ex_ptgt;
   endtask

   task automatic check_outputs(input int step, input bit exp_pt,
                                input logic [31:0] exp_ptgt, input bit exp_mp,
                                input logic [31:0] exp_redir);
      chk("predict_taken", step, {31'd0, PREDICT_TAKEN}, {31'd0, exp_pt});
      chk("predict_target", step, PREDICT_TARGET, exp_ptgt);
      chk("mispredict", step, {31'd0, MISPREDICT}, {31'd0, exp_mp});
      if (exp_mp) chk("redirect_pc", step, REDIRECT_PC, exp_redir);
   endtask

   task automatic clock_edge(input int step);
      @(posedge CLK);
      m_edge();
      #1;
`ifdef BP_PERF_COUNTERS_EN
      chk("branch_count", step, BRANCH_COUNT, m_bc);
      chk("mispredict_count", step, MISPREDICT_COUNT, m_mc);
`else
      if (step < 0) $display("step %0d", step);
`endif
   endtask

   function automatic vec_t mk(input logic rst_n, input logic [31:0] if_pc,
                               input logic ex_v, input logic [31:0] ex_pc,
                               input logic [31:0] ex_tgt, input logic ex_tk,
                               input logic ex_ptk, input logic [31:0] ex_ptgt,
                               input logic exp_pt, input logic [31:0] exp_ptgt,
                               input logic exp_mp, input logic [31:0] exp_redir);
      vec_t v;
      v.rst_n = rst_n;   v.if_pc = if_pc;     v.ex_v = ex_v;
      v.ex_pc = ex_pc;   v.ex_tgt = ex_tgt;   v.ex_tk = ex_tk;
      v.ex_ptk = ex_ptk; v.ex_ptgt = ex_ptgt; v.exp_pt = exp_pt;
      v.exp_ptgt = exp_ptgt; v.exp_mp = exp_mp; v.exp_redir = exp_redir;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      vec_t v;
      logic [31:0] pc_pool [4];
      logic [31:0] tgt;

      m_reset();
      // rst, if_pc, ex_v, ex_pc, ex_tgt, tk, ptk, ptgt | pt, ptgt, mp, redir
      vecs.push_back(mk(0, 32'h100, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h104, 0, 32'h0));
      // allocate 0x100 -> 0x40; same-cycle lookup sees old (empty) entry
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  1, 0, 32'h0,   0, 32'h104, 1, 32'h40));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   32'h0,   1, 0, 32'h0,   1, 32'h40,  0, 32'h0));
      // taken twice more: WT -> ST -> ST
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  1, 1, 32'h40,  1, 32'h40,  0, 32'h0));
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  1, 1, 32'h40,  1, 32'h40,  0, 32'h0));
      // not taken: ST -> WT, still predicts taken
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  0, 1, 32'h40,  1, 32'h40,  1, 32'h104));
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  0, 1, 32'h40,  1, 32'h40,  1, 32'h104));
      // now WNT: predicts not taken; three more not-taken saturate at SNT
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  0, 0, 32'h0,   0, 32'h104, 0, 32'h0));
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  0, 0, 32'h0,   0, 32'h104, 0, 32'h0));
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  0, 0, 32'h0,   0, 32'h104, 0, 32'h0));
      // one taken from SNT lands at WNT (still not taken)
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  1, 0, 32'h0,   0, 32'h104, 1, 32'h40));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h104, 0, 32'h0));
      // direction mispredict on a miss, no table change
      vecs.push_back(mk(1, 32'h200, 1, 32'h200, 32'h500, 0, 1, 32'h500, 0, 32'h204, 1, 32'h204));
      // target mismatch allocates index 1
      vecs.push_back(mk(1, 32'h284, 1, 32'h284, 32'h340, 1, 1, 32'h300, 0, 32'h288, 1, 32'h340));
      vecs.push_back(mk(1, 32'h284, 1, 32'h284, 32'h340, 1, 1, 32'h340, 1, 32'h340, 0, 32'h0));
      // invalid EX never flushes even with disagreeing inputs
      vecs.push_back(mk(1, 32'h200, 0, 32'h200, 32'h340, 1, 0, 32'h0,   0, 32'h204, 0, 32'h0));
      // 0x100 back to WT, then alias 0x140 overwrites index 0 (old data same cycle)
      vecs.push_back(mk(1, 32'h100, 1, 32'h100, 32'h40,  1, 0, 32'h0,   0, 32'h104, 1, 32'h40));
      vecs.push_back(mk(1, 32'h100, 1, 32'h140, 32'h80,  1, 0, 32'h0,   1, 32'h40,  1, 32'h80));
      vecs.push_back(mk(1, 32'h100, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h104, 0, 32'h0));
      // low PC bits are ignored on lookup
      vecs.push_back(mk(1, 32'h143, 0, 32'h0,   32'h0,   0, 0, 32'h0,   1, 32'h80,  0, 32'h0));
      // address wrap on IF_PC+4 and EX_PC+4
      vecs.push_back(mk(1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h8, 0, 1, 32'h8, 0, 32'h0, 1, 32'h0));
      // reset mid-stream with an EX update present: outputs stay input-driven
      vecs.push_back(mk(0, 32'h284, 1, 32'h284, 32'h999, 1, 0, 32'h0,   1, 32'h340, 1, 32'h999));
      vecs.push_back(mk(1, 32'h284, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h288, 0, 32'h0));
      vecs.push_back(mk(1, 32'h140, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 32'h144, 0, 32'h0));

      foreach (vecs[k]) begin
         drive(vecs[k]);
         #1;
         check_outputs(k, vecs[k].exp_pt, vecs[k].exp_ptgt, vecs[k].exp_mp, vecs[k].exp_redir);
         clock_edge(k);
      end

      // ---------------- randomized phase against the model ----------------
      pc_pool[0] = 32'h40;
      pc_pool[1] = 32'h80;
      pc_pool[2] = 32'h1000;
      pc_pool[3] = 32'h0;
      for (int n = 0; n < 1500; n++) begin
         v.rst_n  = ($urandom_range(0, 63) != 0);
         v.if_pc  = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3))};
         v.ex_v   = ($urandom_range(0, 3) != 0);
         v.ex_pc  = {24'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     2'($urandom_range(0, 3))};
         pc_pool[3] = $urandom;
         tgt      = pc_pool[$urandom_range(0, 3)];
         v.ex_tgt = tgt;
         v.ex_tk  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            v.ex_ptk  = m_pred(v.ex_pc);
            v.ex_ptgt = m_ptgt(v.ex_pc);
         end else begin
            v.ex_ptk  = 1'($urandom_range(0, 1));
            v.ex_ptgt = ($urandom_range(0, 1) == 1) ? tgt : pc_pool[$urandom_range(0, 3)];
         end
         drive(v);
         #1;
         check_outputs(1000 + n, m_pred(IF_PC), m_ptgt(IF_PC), m_mispredict(),
                       EX_BRANCH_TAKEN ? EX_TARGET : EX_PC + 32'd4);
         clock_edge(1000 + n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter: ENTRIES, 16, number of direct-mapped predictor entries (index = PC[5:2], tag = PC[31:6]).
REQ-002 SHALL have ports as follows; there is one clock, and reset is synchronous and active-low:
- CLK  input  1  clock; all state changes on its rising edge.
- RESET  input  1  synchronous, active-low reset.
- IF_PC  input  32  fetch-stage PC to look up.
- PREDICT_TAKEN  output  1  prediction for IF_PC.
- PREDICT_TARGET  output  32  predicted target for IF_PC.
- EX_BRANCH_VALID  input  1  a conditional branch resolves in EX this cycle.
- EX_PC  input  32  PC of the resolving branch.
- EX_TARGET  input  32  computed branch target.
- EX_BRANCH_TAKEN  input  1  actual outcome from the EX branch selector.
- EX_PRED_TAKEN  input  1  prediction carried down the pipe with the branch.
- EX_PRED_TARGET  input  32  predicted target carried down the pipe with the branch.
- MISPREDICT  output  1  flush request for IF/ID/EX.
- REDIRECT_PC  output  32  correct next PC on mispredict.

Function
REQ-003 SHALL hold per entry: valid (1), tag (26), target (32) and a 2-bit saturating counter.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
REQ-004 SHALL drive PREDICT_TAKEN combinationally from the IF_PC entry.
- PREDICT_TAKEN = 1 only when valid=1, tag==IF_PC[31:6] and counter[1]=1.
- PREDICT_TARGET = stored target when PREDICT_TAKEN=1, else IF_PC+4 (mod 2^32).
REQ-005 SHALL assert MISPREDICT combinationally when EX_BRANCH_VALID=1 and either:
- EX_BRANCH_TAKEN != EX_PRED_TAKEN, or
- EX_BRANCH_TAKEN=1 and EX_PRED_TARGET != EX_TARGET.
- MISPREDICT SHALL be 0 whenever EX_BRANCH_VALID=0.
REQ-006 SHALL drive REDIRECT_PC = EX_TARGET if EX_BRANCH_TAKEN=1, else EX_PC+4 (mod 2^32).
- REDIRECT_PC is don't-care when MISPREDICT=0.
REQ-007 SHALL update the table at the rising edge of a cycle with EX_BRANCH_VALID=1, on the entry indexed by EX_PC[5:2]:
- Hit, taken: counter increments, saturating at ST; target <= EX_TARGET.
- Hit, not taken: counter decrements, saturating at SNT; target unchanged.
- Miss, taken: entry allocated (overwriting any previous occupant): valid=1, tag=EX_PC[31:6], target=EX_TARGET, counter=WT.
- Miss, not taken: no table change.
REQ-008 SHALL leave the table unchanged in cycles with EX_BRANCH_VALID=0.
REQ-009 SHALL give the lookup the pre-edge table contents when a lookup and an update hit the same index in the same cycle (no bypass); the update is visible from the next cycle.
REQ-010 SHALL treat EX_PC/IF_PC bits [1:0] as ignored.
- A tag mismatch at an occupied index is a miss.

Reset
REQ-011 SHALL, on a rising edge with RESET=0:
- clear every valid bit;
- set every counter to WNT;
- clear all tags and targets to 0.
REQ-012 SHALL ignore any EX update presented in a reset cycle.
- Reset applied mid-operation discards all learned state in one cycle.
REQ-013 SHALL, while the table is invalid:
- give PREDICT_TAKEN=0 and PREDICT_TARGET=IF_PC+4;
- keep MISPREDICT/REDIRECT_PC purely input-driven per REQ-005/006, including during reset.

Configuration
REQ-014 SHALL, with macro BP_PERF_COUNTERS_EN defined, add outputs:
- BRANCH_COUNT (32): increments on each EX_BRANCH_VALID=1 cycle.
- MISPREDICT_COUNT (32): increments on each MISPREDICT=1 cycle.
- Both reset to 0, wrap from 0xFFFFFFFF to 0, and do not count in reset cycles.
REQ-015 SHALL, without BP_PERF_COUNTERS_EN, omit those ports and counters entirely, with no other behavioural difference.

Verification
REQ-016 SHALL cover these scenarios:
- Cold miss: after reset, IF_PC=0x00000100 -> PREDICT_TAKEN=0, PREDICT_TARGET=0x00000104.
- Allocate then predict: EX update PC=0x00000100, taken, target 0x00000040 -> next cycle IF_PC=0x00000100 gives PREDICT_TAKEN=1, PREDICT_TARGET=0x00000040.
- Saturation/hysteresis on PC 0x100: taken x3 then not-taken x1 -> still predicts taken (ST->WT); second not-taken -> predicts not taken (WNT); further not-taken x3 -> counter stays SNT.
- Mispredict: EX_BRANCH_VALID=1, EX_PC=0x200, EX_BRANCH_TAKEN=0, EX_PRED_TAKEN=1 -> MISPREDICT=1, REDIRECT_PC=0x204.
- Target mismatch: taken, EX_PRED_TAKEN=1, EX_PRED_TARGET=0x300, EX_TARGET=0x340 -> MISPREDICT=1, REDIRECT_PC=0x340; matching targets -> MISPREDICT=0.
- Alias + same-cycle + reset:
  - PC 0x00000100 allocated, then 0x00000140 taken at index 0 -> 0x100 lookup misses.
  - Lookup of an index in its update cycle returns old data.
  - RESET=0 for one cycle mid-stream -> all lookups miss; with BP_PERF_COUNTERS_EN both counters read 0.
